// File: rtl/mem_pkg.sv
// Shared memory-subsystem types and constants, used by data_sram and the LSU.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [31:0] ADDR_BASE_DEFAULT = 32'h8000_0000;
  localparam int          WMASK_W           = 4;
  localparam int          CNT_W             = 4;

endpackage : mem_pkg

// File: rtl/data_sram_array.sv
// Word-organised storage with per-byte-lane writes and a registered read port
// that captures the addressed word when a read commits.
module data_sram_array
  import mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               en_i,
  input  logic               wen_i,
  input  logic [AW-1:0]      idx_i,
  input  logic [31:0]        wdata_i,
  input  logic [WMASK_W-1:0] wmask_i,
  output logic [31:0]        rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // NOTE: the storage array has no reset; only control state needs a known
  // value after reset, and resetting a RAM prevents mapping it to a macro.
  always_ff @(posedge clk) begin
    if (en_i && wen_i) begin
      for (int i = 0; i < WMASK_W; i++) begin
        if (wmask_i[i]) mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (en_i && !wen_i) rdata_q <= mem_q[idx_i];
  end

  assign rdata_o = rdata_q;

endmodule : data_sram_array

// File: rtl/data_sram.sv
// Single-outstanding SRAM responder: accepts one request, waits LATENCY
// cycles, commits the access, then holds the response until it is taken.
module data_sram
  import mem_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = ADDR_BASE_DEFAULT,
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_wen,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  input  logic [WMASK_W-1:0] req_wmask,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [31:0]        resp_rdata,
  output logic               resp_err
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(4 * DEPTH);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 wen_q, wen_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [WMASK_W-1:0]   wmask_q, wmask_d;
  logic                 err_q, err_d;

  logic                 req_hs;
  logic                 resp_hs;
  logic                 commit;
  logic [31:0]          offset;
  logic                 in_range;
  logic [31:0]          arr_rdata;

  // Offset is computed once; a 33-bit bound keeps the top of the window
  // correct even when ADDR_BASE + 4*DEPTH would overflow 32 bits.
  assign offset   = addr_q - ADDR_BASE;
  assign in_range = (addr_q >= ADDR_BASE) && ({1'b0, offset} < SPAN);

  assign req_ready = (state_q == IDLE) && !rst;
  assign req_hs    = req_valid && req_ready;
  assign resp_hs   = (state_q == RESP) && resp_ready;
  assign commit    = (state_q == BUSY) && (cnt_q == '0);

  // NOTE: every always_comb output gets a default first so that no path
  // through the case statement leaves a signal unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_hs) begin
          wen_d   = req_wen;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wmask_d = req_wmask;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (commit) begin
          err_d   = !in_range;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (resp_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of its inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      err_q   <= err_d;
    end
  end

  data_sram_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .en_i    (commit && in_range && !rst),
    .wen_i   (wen_q),
    .idx_i   (offset[AW+1:2]),
    .wdata_i (wdata_q),
    .wmask_i (wmask_q),
    .rdata_o (arr_rdata)
  );

  // Read data is only exposed for successful reads; the array register keeps
  // its value across the whole RESP phase, so the output stays stable.
  assign resp_valid = (state_q == RESP);
  assign resp_err   = (state_q == RESP) && err_q;
  assign resp_rdata = ((state_q == RESP) && !err_q && !wen_q) ? arr_rdata : '0;

endmodule : data_sram

// File: tb/tb_data_sram.sv
// Directed bench for data_sram: default build plus LATENCY=1 and LATENCY=15.
module tb_data_sram;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_wen    [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic [3:0]  req_wmask  [3];
  logic        resp_valid [3];
  logic        resp_ready [3];
  logic [31:0] resp_rdata [3];
  logic        resp_err   [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_sram #(.LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wen(req_wen[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wmask(req_wmask[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  data_sram #(.LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wen(req_wen[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wmask(req_wmask[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  data_sram #(.LATENCY(15)) dut_l15 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_wen(req_wen[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_wmask(req_wmask[2]),
    .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
    .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction on instance k: accept, measure latency, check
  // the response (held for 'hold' cycles of backpressure), then release it.
  task automatic txn(input int k, input string tag, input logic wen,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] wmask, input int exp_lat,
                     input logic [31:0] exp_rdata, input logic exp_err,
                     input int hold);
    int lat;
    int w;
    req_wen[k]   = wen;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    req_wmask[k] = wmask;
    req_valid[k] = 1'b1;
    w = 0;
    while (!req_ready[k] && w < 50) begin
      tick();
      w++;
    end
    check({tag, " req_ready before accept"}, 32'(req_ready[k]), 32'd1);
    tick();
    req_valid[k] = 1'b0;
    check({tag, " resp_valid after accept"}, 32'(resp_valid[k]), 32'd0);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!resp_valid[k] && lat < 40);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " rdata"}, resp_rdata[k], exp_rdata);
    check({tag, " err"}, 32'(resp_err[k]), 32'(exp_err));
    check({tag, " req_ready in RESP"}, 32'(req_ready[k]), 32'd0);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, " held valid"}, 32'(resp_valid[k]), 32'd1);
      check({tag, " held rdata"}, resp_rdata[k], exp_rdata);
      check({tag, " held err"}, 32'(resp_err[k]), 32'(exp_err));
      check({tag, " held req_ready"}, 32'(req_ready[k]), 32'd0);
    end
    resp_ready[k] = 1'b1;
    tick();
    resp_ready[k] = 1'b0;
    check({tag, " valid after resp hs"}, 32'(resp_valid[k]), 32'd0);
    check({tag, " req_ready after resp hs"}, 32'(req_ready[k]), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_valid[k]  = 1'b0;
      req_wen[k]    = 1'b0;
      req_addr[k]   = '0;
      req_wdata[k]  = '0;
      req_wmask[k]  = '0;
      resp_ready[k] = 1'b0;
    end
    tick();
    tick();
    check("reset req_ready", 32'(req_ready[0]), 32'd0);
    check("reset resp_valid", 32'(resp_valid[0]), 32'd0);
    check("reset resp_rdata", resp_rdata[0], 32'h0);
    check("reset resp_err", 32'(resp_err[0]), 32'd0);
    rst = 1'b0;
    tick();

    // Full write, read back, partial-lane write, empty mask.
    txn(0, "wr full", 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'b1111, 2, 32'h0, 1'b0, 0);
    txn(0, "rd full", 1'b0, 32'h8000_0010, 32'h0, 4'b0000, 2, 32'hDEAD_BEEF, 1'b0, 0);
    txn(0, "wr lane1", 1'b1, 32'h8000_0010, 32'h0000_5500, 4'b0010, 2, 32'h0, 1'b0, 0);
    txn(0, "rd lane1", 1'b0, 32'h8000_0010, 32'h0, 4'b0000, 2, 32'hDEAD_55EF, 1'b0, 0);
    txn(0, "wr nomask", 1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'b0000, 2, 32'h0, 1'b0, 0);
    txn(0, "rd nomask", 1'b0, 32'h8000_0010, 32'h0, 4'b0000, 2, 32'hDEAD_55EF, 1'b0, 0);
    txn(0, "rd unaligned", 1'b0, 32'h8000_0013, 32'h0, 4'b0000, 2, 32'hDEAD_55EF, 1'b0, 0);

    // Range boundaries; the out-of-range write would alias word 4 if not blocked.
    txn(0, "rd below", 1'b0, 32'h7FFF_FFFC, 32'h0, 4'b0000, 2, 32'h0, 1'b1, 0);
    txn(0, "rd above", 1'b0, 32'h8000_1000, 32'h0, 4'b0000, 2, 32'h0, 1'b1, 0);
    txn(0, "wr above", 1'b1, 32'h8000_1010, 32'h0, 4'b1111, 2, 32'h0, 1'b1, 0);
    txn(0, "rd alias", 1'b0, 32'h8000_0010, 32'h0, 4'b0000, 2, 32'hDEAD_55EF, 1'b0, 0);
    txn(0, "wr last", 1'b1, 32'h8000_0FFC, 32'h1234_5678, 4'b1111, 2, 32'h0, 1'b0, 0);
    txn(0, "rd last", 1'b0, 32'h8000_0FFC, 32'h0, 4'b0000, 2, 32'h1234_5678, 1'b0, 0);

    // Backpressure on a read response.
    txn(0, "rd backpress", 1'b0, 32'h8000_0010, 32'h0, 4'b0000, 2, 32'hDEAD_55EF, 1'b0, 5);

    // Reset during BUSY abandons the write.
    txn(0, "wr old", 1'b1, 32'h8000_0020, 32'h1122_3344, 4'b1111, 2, 32'h0, 1'b0, 0);
    req_wen[0]   = 1'b1;
    req_addr[0]  = 32'h8000_0020;
    req_wdata[0] = 32'hAABB_CCDD;
    req_wmask[0] = 4'b1111;
    req_valid[0] = 1'b1;
    check("abort req_ready", 32'(req_ready[0]), 32'd1);
    tick();
    req_valid[0] = 1'b0;
    check("abort busy valid", 32'(resp_valid[0]), 32'd0);
    rst = 1'b1;
    #1;
    check("abort req_ready in rst", 32'(req_ready[0]), 32'd0);
    tick();
    check("abort valid in rst", 32'(resp_valid[0]), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort no response", 32'(resp_valid[0]), 32'd0);
    end
    txn(0, "rd after abort", 1'b0, 32'h8000_0020, 32'h0, 4'b0000, 2, 32'h1122_3344, 1'b0, 0);

    // Latency extremes.
    txn(1, "l1 wr", 1'b1, 32'h8000_0040, 32'hCAFE_F00D, 4'b1111, 1, 32'h0, 1'b0, 0);
    txn(1, "l1 rd", 1'b0, 32'h8000_0040, 32'h0, 4'b0000, 1, 32'hCAFE_F00D, 1'b0, 0);
    txn(2, "l15 wr", 1'b1, 32'h8000_0044, 32'h0BAD_CAFE, 4'b0101, 15, 32'h0, 1'b0, 0);
    txn(2, "l15 err", 1'b0, 32'h9000_0000, 32'h0, 4'b0000, 15, 32'h0, 1'b1, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_data_sram
